// File: rtl/alu_pkg.sv
// Shared definitions for multicycle_alu: opcodes, condition-code bit
// positions and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the master holds valid and its payload stable until then, and
// the slave holds result/cc/illegal stable while out_valid is high and
// out_ready is low.
interface multicycle_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       cc;
  logic             illegal;

  modport master (
    output in_valid, aluop, valA, valB, out_ready,
    input  in_ready, out_valid, result, cc, illegal
  );

  modport slave (
    input  in_valid, aluop, valA, valB, out_ready,
    output in_ready, out_valid, result, cc, illegal
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, WIDTH
// iterations after start. done is high during the final iteration and
// product then shows the finished signed 2*WIDTH-bit product.
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  // acc = {upper partial sum, multiplier, appended q(-1) bit}
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_next;
  logic [WIDTH:0]     upper_ext;
  logic [WIDTH:0]     mcand_ext;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               busy;

  // One Booth step: add/subtract multiplicand on 01/10, then arithmetic
  // shift right. The add is one bit wider so the most negative multiplicand
  // cannot overflow the partial sum.
  always_comb begin
    upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand[WIDTH-1], mcand};
    case (acc[1:0])
      2'b01:   sum = upper_ext + mcand_ext;
      2'b10:   sum = upper_ext - mcand_ext;
      default: sum = upper_ext;
    endcase
    acc_next = {sum, acc[WIDTH:1]};
  end

  assign done    = busy & (cnt == CW'(WIDTH - 1));
  assign product = acc_next[2*WIDTH:1];

  // Load operands on start, then iterate until the final step retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b, 1'b0};
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and NZCV flags.
// Optional multiplier: define ALU_MUL_EN to build the Booth multiplier;
// without it MUL is reported as an illegal opcode.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_alu_if.slave     bus,
  output alu_state_e          dbg_state
);

  alu_state_e         state;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ovf;

  logic               sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH-1:0]   shar_res;
  logic [SHW-1:0]     rot_amt;
  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;

  logic [WIDTH-1:0]   nxt_res;
  logic               nxt_c;
  logic               nxt_v;
  logic               nxt_ill;
  logic [3:0]         nxt_cc;

  assign bus.in_ready = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign dbg_state    = state;

  // Datapath pieces shared by the opcode decode below.
  assign sub      = (bus.aluop == OP_SUB);
  assign b_eff    = sub ? ~bus.valB : bus.valB;
  assign sum      = {1'b0, bus.valA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign shl_ext  = {1'b0, bus.valA} << bus.valB;
  assign shar_res = $signed(bus.valA) >>> bus.valB;
  assign rot_amt  = bus.valB[SHW-1:0];
  assign rot_l    = {bus.valA, bus.valA} << rot_amt;
  assign rot_r    = {bus.valA, bus.valA} >> rot_amt;

  // Single-cycle result, carry/overflow and legality for the offered opcode.
  always_comb begin
    nxt_res = '0;
    nxt_c   = 1'b0;
    nxt_v   = 1'b0;
    nxt_ill = 1'b0;
    is_mul  = 1'b0;
    case (bus.aluop)
      OP_ADD, OP_SUB: begin
        nxt_res = sum[WIDTH-1:0];
        nxt_c   = sum[WIDTH];
        nxt_v   = (bus.valA[WIDTH-1] == b_eff[WIDTH-1]) &
                  (sum[WIDTH-1] != bus.valA[WIDTH-1]);
      end
      OP_SHL: begin
        nxt_res = shl_ext[WIDTH-1:0];
        nxt_c   = shl_ext[WIDTH];
      end
      OP_SHAR: nxt_res = shar_res;
      OP_SHLR: nxt_res = bus.valA >> bus.valB;
      OP_RL:   nxt_res = rot_l[2*WIDTH-1:WIDTH];
      OP_RR:   nxt_res = rot_r[WIDTH-1:0];
      OP_AND:  nxt_res = bus.valA & bus.valB;
      OP_OR:   nxt_res = bus.valA | bus.valB;
      OP_XOR:  nxt_res = bus.valA ^ bus.valB;
      OP_NOT:  nxt_res = ~bus.valB;
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul  = 1'b1;
`else
      OP_MUL:  nxt_ill = 1'b1;
`endif
      default: nxt_ill = 1'b1;
    endcase
    nxt_cc = nxt_ill ? 4'b0100
                     : {nxt_res[WIDTH-1], ~|nxt_res, nxt_c, nxt_v};
  end

`ifdef ALU_MUL_EN
  logic mul_start;
  assign mul_start = accept & is_mul;

  booth_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.valA),
    .b       (bus.valB),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Product overflows when the bits from the result sign upward disagree.
  assign mul_res = mul_product[WIDTH-1:0];
  assign mul_ovf = ~((&mul_product[2*WIDTH-1:WIDTH-1]) |
                     (~|mul_product[2*WIDTH-1:WIDTH-1]));

  // Controller: accept, wait for the multiplier, present result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.cc        <= '0;
      bus.illegal   <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        state         <= ST_MUL;
        bus.out_valid <= 1'b0;
      end else begin
        state         <= ST_DONE;
        bus.out_valid <= 1'b1;
        bus.result    <= nxt_res;
        bus.cc        <= nxt_cc;
        bus.illegal   <= nxt_ill;
      end
    end else if ((state == ST_DONE) && bus.out_ready) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
    end else if ((state == ST_MUL) && mul_done) begin
      state         <= ST_DONE;
      bus.out_valid <= 1'b1;
      bus.result    <= mul_res;
      bus.cc        <= {mul_res[WIDTH-1], ~|mul_res, mul_ovf, mul_ovf};
      bus.illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu (WIDTH=16): directed cases, randomized traffic
// against an arithmetic reference model, backpressure, streaming, reset.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  alu_state_e dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [20:0] exp_q[$];

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: {illegal, N, Z, C, V, result} from plain integer arithmetic.
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int ai, bi, sa, sb, r, c, v, ill, k;
    longint p;
    logic [15:0] rr;
    ai = int'(a); bi = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 0; c = 0; v = 0; ill = 0;
    k = bi % 16;
    case (op)
      4'd1:  begin r = ai + bi; c = (r > 65535) ? 1 : 0; v = (sa + sb > 32767 || sa + sb < -32768) ? 1 : 0; end
      4'd2:  begin r = ai - bi; c = (ai >= bi) ? 1 : 0; v = (sa - sb > 32767 || sa - sb < -32768) ? 1 : 0; end
      4'd5:  begin r = (bi >= 16) ? 0 : (ai << bi); c = (bi >= 1 && bi <= 16) ? ((ai >> (16 - bi)) & 1) : 0; end
      4'd6:  r = (bi >= 16) ? ((sa < 0) ? 65535 : 0) : (sa >>> bi);
      4'd7:  r = (bi >= 16) ? 0 : (ai >> bi);
      4'd8:  r = (ai << k) | (ai >> (16 - k));
      4'd9:  r = (ai >> k) | (ai << (16 - k));
      4'd11: r = ai & bi;
      4'd12: r = ai | bi;
      4'd13: r = ai ^ bi;
      4'd14: r = 65535 - bi;
`ifdef ALU_MUL_EN
      4'd15: begin
        p = longint'(sa) * longint'(sb);
        r = int'(p & 64'hFFFF);
        v = (p > 32767 || p < -32768) ? 1 : 0;
        c = v;
      end
`endif
      default: ill = 1;
    endcase
    rr = r[15:0];
    if (ill != 0) rr = 16'h0;
    return {ill[0], rr[15], (rr == 16'h0), c[0], v[0], rr};
  endfunction

  function automatic int model_lat(input logic [3:0] op);
`ifdef ALU_MUL_EN
    if (op == 4'd15) return 17;
`endif
    return 1;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.aluop     = 4'h0;
    bus.valA      = '0;
    bus.valB      = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic send_wait(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [20:0] got, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluop = op; bus.valA = a; bus.valB = b; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus.illegal, bus.cc, bus.result};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if ({bus.illegal, bus.cc, bus.result} !== 21'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {bus.illegal, bus.cc, bus.result});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op[10];
    logic [15:0] t_a[10], t_b[10];
    logic [20:0] t_exp[10];
    int          t_lat[10];
    logic [20:0] got;
    int          lat;
    t_op[0] = OP_ADD;  t_a[0] = 16'h7FFF; t_b[0] = 16'h0001; t_exp[0] = {1'b0, 4'b1001, 16'h8000}; t_lat[0] = 1;
    t_op[1] = OP_SUB;  t_a[1] = 16'h0005; t_b[1] = 16'h0005; t_exp[1] = {1'b0, 4'b0110, 16'h0000}; t_lat[1] = 1;
    t_op[2] = OP_SUB;  t_a[2] = 16'h0003; t_b[2] = 16'h0005; t_exp[2] = {1'b0, 4'b1000, 16'hFFFE}; t_lat[2] = 1;
    t_op[3] = OP_SHAR; t_a[3] = 16'h8000; t_b[3] = 16'd20;   t_exp[3] = {1'b0, 4'b1000, 16'hFFFF}; t_lat[3] = 1;
    t_op[4] = OP_SHL;  t_a[4] = 16'h8001; t_b[4] = 16'd1;    t_exp[4] = {1'b0, 4'b0010, 16'h0002}; t_lat[4] = 1;
    t_op[5] = OP_RR;   t_a[5] = 16'h0001; t_b[5] = 16'd17;   t_exp[5] = {1'b0, 4'b1000, 16'h8000}; t_lat[5] = 1;
    t_op[6] = 4'b0011; t_a[6] = 16'h1234; t_b[6] = 16'h5678; t_exp[6] = {1'b1, 4'b0100, 16'h0000}; t_lat[6] = 1;
    t_op[7] = OP_NOT;  t_a[7] = 16'h0000; t_b[7] = 16'h00FF; t_exp[7] = {1'b0, 4'b1000, 16'hFF00}; t_lat[7] = 1;
`ifdef ALU_MUL_EN
    t_op[8] = OP_MUL;  t_a[8] = 16'hFFFD; t_b[8] = 16'h0007; t_exp[8] = {1'b0, 4'b1000, 16'hFFEB}; t_lat[8] = 17;
    t_op[9] = OP_MUL;  t_a[9] = 16'h0100; t_b[9] = 16'h0100; t_exp[9] = {1'b0, 4'b0111, 16'h0000}; t_lat[9] = 17;
`else
    t_op[8] = OP_MUL;  t_a[8] = 16'hFFFD; t_b[8] = 16'h0007; t_exp[8] = {1'b1, 4'b0100, 16'h0000}; t_lat[8] = 1;
    t_op[9] = OP_MUL;  t_a[9] = 16'h0100; t_b[9] = 16'h0100; t_exp[9] = {1'b1, 4'b0100, 16'h0000}; t_lat[9] = 1;
`endif
    for (int i = 0; i < 10; i++) begin
      send_wait(t_op[i], t_a[i], t_b[i], got, lat);
      checks++;
      if (got !== t_exp[i]) begin
        errors++; $display("FAIL directed_%0d value got %h want %h", i, got, t_exp[i]);
      end
      checks++;
      if (lat != t_lat[i]) begin
        errors++; $display("FAIL directed_%0d latency got %0d want %0d", i, lat, t_lat[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        pending = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0;
    logic        acc_s, pop_s, hold_prev = 1'b0;
    logic [20:0] obs, prev_obs = '0, exp_v;
    int          drain;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        op = 4'($urandom_range(0, 15));
        a  = 16'($urandom);
        b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      end
      bus.in_valid  = pending;
      bus.aluop     = op;
      bus.valA      = a;
      bus.valB      = b;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      obs   = {bus.illegal, bus.cc, bus.result};
      acc_s = bus.in_valid & bus.in_ready;
      pop_s = bus.out_valid & bus.out_ready;
      if (hold_prev) begin
        checks++;
        if (!bus.out_valid || obs !== prev_obs) begin
          errors++; $display("FAIL rand_hold_stable cyc %0d got %h want %h", cyc, obs, prev_obs);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rand_in_ready_stall cyc %0d got 1 want 0", cyc); end
      end
      hold_prev = bus.out_valid & ~bus.out_ready;
      prev_obs  = obs;
      @(posedge clk);
      if (pop_s) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_output cyc %0d got %h want none", cyc, obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin errors++; $display("FAIL rand_result cyc %0d got %h want %h", cyc, obs, exp_v); end
        end
      end
      if (acc_s) begin
        exp_q.push_back(model(op, a, b));
        pending = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 40) begin
      #1;
      if (bus.out_valid) begin
        exp_v = exp_q.pop_front();
        obs = {bus.illegal, bus.cc, bus.result};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rand_drain got %h want %h", obs, exp_v); end
      end
      @(negedge clk);
      drain++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain_timeout got %0d pending want 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluop = OP_ADD; bus.valA = 16'h1234; bus.valB = 16'h1111;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // keep a different request waiting; it must not be taken while stalled
    bus.aluop = OP_SUB; bus.valA = 16'h0009; bus.valB = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.illegal, bus.cc, bus.result} !== {1'b0, 4'b0000, 16'h2345}) begin
        errors++; $display("FAIL bp_hold_%0d got %b/%h want 1/%h", i, bus.out_valid,
                           {bus.illegal, bus.cc, bus.result}, {1'b0, 4'b0000, 16'h2345});
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %b want 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.illegal, bus.cc, bus.result} !== {1'b0, 4'b0010, 16'h0005}) begin
      errors++; $display("FAIL bp_release got %b/%h want 1/%h", bus.out_valid,
                         {bus.illegal, bus.cc, bus.result}, {1'b0, 4'b0010, 16'h0005});
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.aluop = OP_ADD;
      bus.valA = 16'(100 + i * 3); bus.valB = 16'(i * 7);
      bus.out_ready = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d got %b want 1", i, bus.in_ready); end
      @(posedge clk); #1;
      want = 16'(100 + i * 10);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== want) begin
        errors++; $display("FAIL b2b_result_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.result, want);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.aluop = (pass == 0) ? OP_MUL : OP_ADD;
      bus.valA = 16'h0003; bus.valB = 16'h0004;
      bus.out_ready = (pass == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rst_mid_%0d out_valid got %0d cycles want 0", pass, seen); end
      checks++;
      if (bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
        errors++; $display("FAIL rst_mid_%0d idle got %b/%0d want 1/%0d", pass, bus.in_ready, dbg_state, ST_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Last-resort bound so a stuck handshake cannot hang the run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
